// File: rtl/mac_pkg.sv
// Shared definitions for the product accumulator slice.
//   state_e : accumulator FSM states (ACC collecting beats, HOLD presenting a result)
//   PROD_W  : width of one product from the 4x4 multiplier stage
package mac_pkg;

  localparam int PROD_W = 8;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/prod_accumulator_if.sv
// Handshake bundle between the product source, the accumulator and the result sink.
//   in_valid/in_ready/in_prod/in_last     : product stream into the accumulator
//   out_valid/out_ready/out_sum/out_count/out_ovf : group result stream out
// master : drives the product stream and consumes the result (testbench / upstream)
// slave  : the accumulator itself
interface prod_accumulator_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  import mac_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/acc_adder.sv
// W-bit adder with carry-out, built as a Kogge-Stone parallel prefix tree.
//   a, b : addends
//   sum  : (a + b) mod 2^W
//   cout : carry out of bit W-1
// Cells: pass (i < D), GREY (D <= i < 2D, lower span already reaches bit 0 so
// only the generate term is needed) and BLACK (full generate/propagate merge).
module acc_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int L = $clog2(W);

  logic [L:0][W-1:0] g;
  logic [L:0][W-1:0] pp;
  logic              unused_pp;

  assign g[0]  = a & b;
  assign pp[0] = a ^ b;

  for (genvar lv = 0; lv < L; lv++) begin : g_lvl
    localparam int D = 1 << lv;
    for (genvar i = 0; i < W; i++) begin : g_bit
      if (i < D) begin : g_pass
        assign g[lv+1][i]  = g[lv][i];
        assign pp[lv+1][i] = pp[lv][i];
      end else if (i < 2*D) begin : g_grey
        assign g[lv+1][i]  = g[lv][i] | (pp[lv][i] & g[lv][i-D]);
        assign pp[lv+1][i] = pp[lv][i];
      end else begin : g_black
        assign g[lv+1][i]  = g[lv][i] | (pp[lv][i] & g[lv][i-D]);
        assign pp[lv+1][i] = pp[lv][i] & pp[lv][i-D];
      end
    end
  end

  // After L levels g[L][i] is the carry out of bits [i:0] (no carry-in).
  assign sum  = pp[0] ^ {g[L][W-2:0], 1'b0};
  assign cout = g[L][W-1];

  // Propagate terms past the grey cells are never consumed; fold them here.
  assign unused_pp = ^pp;

endmodule

// File: rtl/prod_accumulator.sv
// Accumulates a group of 8-bit products and presents the group total.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of prod_accumulator_if
//              in_*  : product beats, in_last closes a group
//              out_* : sum (mod 2^ACC_W), beat count, sticky overflow
// A group closes on in_last or when it reaches MAX_LEN beats. The result is
// held until taken; the handshake cycle itself accepts no input beat.
module prod_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W   = 16,
  parameter int MAX_LEN = 15,
  parameter int CNT_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  prod_accumulator_if.slave bus
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             ovf_q,   ovf_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_cout;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             close;

  acc_adder #(.W(ACC_W)) u_add (
    .a    (acc_q),
    .b    (ACC_W'(bus.in_prod)),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign cnt_inc = cnt_q + 1'b1;
  assign accept  = bus.in_valid && (state_q == ACC);
  assign close   = accept && (bus.in_last || (cnt_inc == CNT_W'(MAX_LEN)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state and datapath
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ACC: begin
        if (accept) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_cout;
          if (close) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // Outputs: pure decode of registered state, no path from out_ready.
  always_comb begin
    bus.in_ready  = (state_q == ACC);
    bus.out_valid = (state_q == HOLD);
    bus.out_sum   = acc_q;
    bus.out_count = cnt_q;
    bus.out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_prod_accumulator.sv
module tb_prod_accumulator;
  import mac_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  prod_accumulator_if #(.ACC_W(16), .CNT_W(8)) i0 ();
  prod_accumulator_if #(.ACC_W(10), .CNT_W(8)) i1 ();
  prod_accumulator_if #(.ACC_W(16), .CNT_W(8)) i2 ();

  prod_accumulator #(.ACC_W(16), .MAX_LEN(15), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(i0));
  prod_accumulator #(.ACC_W(10), .MAX_LEN(15), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(i1));
  prod_accumulator #(.ACC_W(16), .MAX_LEN(4),  .CNT_W(8)) u2 (.clk(clk), .rst(rst), .bus(i2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    i0.in_valid = 0; i0.in_prod = 0; i0.in_last = 0; i0.out_ready = 0;
    i1.in_valid = 0; i1.in_prod = 0; i1.in_last = 0; i1.out_ready = 0;
    i2.in_valid = 0; i2.in_prod = 0; i2.in_last = 0; i2.out_ready = 0;

    // Reset for two cycles
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst_in_ready",  i0.in_ready, 1);
    chk("rst_out_valid", i0.out_valid, 0);
    chk("rst_sum",       i0.out_sum, 0);
    chk("rst_count",     i0.out_count, 0);
    chk("rst_ovf",       i0.out_ovf, 0);
    chk("rst_u1_ready",  i1.in_ready, 1);
    chk("rst_u2_ready",  i2.in_ready, 1);

    // 15 + 225 + 1 = 241
    i0.out_ready = 1;
    i0.in_valid = 1; i0.in_prod = 15; tick();
    chk("g1_valid_b1", i0.out_valid, 0);
    i0.in_prod = 225; tick();
    chk("g1_valid_b2", i0.out_valid, 0);
    chk("g1_cnt_b2",   i0.out_count, 2);
    i0.in_prod = 1; i0.in_last = 1; tick();
    chk("g1_valid", i0.out_valid, 1);
    chk("g1_sum",   i0.out_sum, 241);
    chk("g1_count", i0.out_count, 3);
    chk("g1_ovf",   i0.out_ovf, 0);
    chk("g1_ready_hold", i0.in_ready, 0);
    i0.in_valid = 0; i0.in_last = 0; tick();
    chk("g1_ready_after", i0.in_ready, 1);
    chk("g1_valid_after", i0.out_valid, 0);
    chk("g1_count_after", i0.out_count, 0);

    // Back-pressure: result held for 5 cycles while input keeps offering beats
    i0.out_ready = 0;
    i0.in_valid = 1; i0.in_prod = 10; i0.in_last = 1; tick();
    i0.in_prod = 99; i0.in_last = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_ready", i0.in_ready, 0);
      chk("bp_valid", i0.out_valid, 1);
      chk("bp_sum",   i0.out_sum, 10);
      chk("bp_count", i0.out_count, 1);
    end
    i0.out_ready = 1; tick();
    i0.in_valid = 0;
    chk("bp_valid_after", i0.out_valid, 0);
    chk("bp_sum_after",   i0.out_sum, 0);
    tick();
    chk("bp_bubble_sum",   i0.out_sum, 0);
    chk("bp_bubble_count", i0.out_count, 0);
    chk("bp_one_transfer", i0.out_valid, 0);

    // Reset mid-group, with a closing beat offered during reset
    i0.in_valid = 1; i0.in_prod = 3; tick();
    i0.in_prod = 4; tick();
    chk("mid_sum",   i0.out_sum, 7);
    chk("mid_count", i0.out_count, 2);
    rst = 1; i0.in_prod = 50; i0.in_last = 1; tick();
    rst = 0; i0.in_valid = 0; i0.in_last = 0;
    chk("mid_rst_valid", i0.out_valid, 0);
    chk("mid_rst_sum",   i0.out_sum, 0);
    chk("mid_rst_count", i0.out_count, 0);
    tick();
    chk("mid_rst_noemit", i0.out_valid, 0);
    i0.in_valid = 1; i0.in_prod = 7; tick();
    i0.in_prod = 8; i0.in_last = 1; tick();
    i0.in_valid = 0; i0.in_last = 0; i0.out_ready = 0;
    chk("post_rst_valid", i0.out_valid, 1);
    chk("post_rst_sum",   i0.out_sum, 15);
    chk("post_rst_count", i0.out_count, 2);

    // Reset in HOLD beats a simultaneous handshake
    rst = 1; i0.out_ready = 1; tick();
    rst = 0;
    chk("hold_rst_valid", i0.out_valid, 0);
    chk("hold_rst_sum",   i0.out_sum, 0);
    chk("hold_rst_ready", i0.in_ready, 1);

    // ACC_W=10: 5 x 225 = 1125 -> 101 with overflow
    i1.out_ready = 1;
    i1.in_valid = 1; i1.in_prod = 225;
    repeat (4) tick();
    chk("w10_part_sum", i1.out_sum, 900);
    chk("w10_part_ovf", i1.out_ovf, 0);
    i1.in_last = 1; tick();
    chk("w10_valid", i1.out_valid, 1);
    chk("w10_sum",   i1.out_sum, 101);
    chk("w10_count", i1.out_count, 5);
    chk("w10_ovf",   i1.out_ovf, 1);
    i1.in_valid = 0; i1.in_last = 0; tick();
    chk("w10_ovf_clr",   i1.out_ovf, 0);
    chk("w10_valid_clr", i1.out_valid, 0);

    // MAX_LEN=4: six beats of 1 without in_last
    i2.out_ready = 0;
    i2.in_valid = 1; i2.in_prod = 1; i2.in_last = 0;
    repeat (3) tick();
    chk("ml_valid_b3", i2.out_valid, 0);
    tick();
    chk("ml_valid", i2.out_valid, 1);
    chk("ml_sum",   i2.out_sum, 4);
    chk("ml_count", i2.out_count, 4);
    i2.out_ready = 1; tick();
    i2.out_ready = 0;
    chk("ml_bubble_count", i2.out_count, 0);
    tick(); tick();
    i2.in_valid = 0;
    chk("ml_next_valid", i2.out_valid, 0);
    chk("ml_next_sum",   i2.out_sum, 2);
    chk("ml_next_count", i2.out_count, 2);

    // in_last on the MAX_LEN beat closes a single group
    i2.in_valid = 1; tick();
    i2.in_last = 1; tick();
    i2.in_valid = 0; i2.in_last = 0;
    chk("ml_last_valid", i2.out_valid, 1);
    chk("ml_last_count", i2.out_count, 4);
    i2.out_ready = 1; tick();
    chk("ml_last_valid_after", i2.out_valid, 0);
    chk("ml_last_count_after", i2.out_count, 0);
    tick();
    chk("ml_last_single", i2.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 16: accumulator and result width in bits, minimum 8.
REQ-002 SHALL have parameter MAX_LEN, default 15: maximum products per group, range 1..255.
REQ-003 SHALL have parameter CNT_W, default 8: width of the group-count output, sized to hold MAX_LEN.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1: in_prod and in_last are valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts a product this cycle.
REQ-009 SHALL have port in_prod, input, 8: unsigned 8-bit product from the 4x4 multiplier stage.
REQ-010 SHALL have port in_last, input, 1: this product closes the current group.
REQ-011 SHALL have port out_valid, output, 1: result fields are valid.
REQ-012 SHALL have port out_ready, input, 1: downstream takes the result.
REQ-013 SHALL have port out_sum, output, ACC_W: group sum modulo 2^ACC_W.
REQ-014 SHALL have port out_count, output, CNT_W: number of products in the group.
REQ-015 SHALL have port out_ovf, output, 1: at least one addition in the group carried out of ACC_W.

Function
REQ-016 SHALL accept a beat when in_valid && in_ready.
REQ-017 SHALL implement two states: ACC and HOLD.
REQ-018 In ACC: in_ready=1 and out_valid=0.
REQ-019 In HOLD: in_ready=0 and out_valid=1.
REQ-020 On accept in ACC: acc <= acc + zero-extended in_prod; cnt <= cnt+1; ovf <= ovf | carry-out.
REQ-021 The group SHALL close on an accepted beat with in_last=1, or when that beat makes cnt equal MAX_LEN, whichever comes first.
REQ-022 On group close, the next state SHALL be HOLD, with out_sum/out_count/out_ovf equal to the totals including the closing beat, and out_valid asserted the cycle after the closing beat (latency 1).
REQ-023 In HOLD, all result fields SHALL remain stable until out_valid && out_ready.
REQ-024 On out_valid && out_ready: next state SHALL be ACC with acc=0, cnt=0, ovf=0; no input beat is accepted in that cycle (one-cycle bubble).
REQ-025 in_last on a beat that also reaches MAX_LEN SHALL close exactly one group.
REQ-026 Accumulator addition SHALL wrap modulo 2^ACC_W; out_ovf is sticky within the group.
REQ-027 in_valid=0 in ACC SHALL leave all state unchanged.
REQ-028 in_ready SHALL be a registered-state decode only, with no combinational path from out_ready.

Reset
REQ-029 While rst=1 at a clock edge: state=ACC, acc=0, cnt=0, ovf=0.
REQ-030 After that reset edge, out_valid=0, in_ready=1, out_sum=0, out_count=0, out_ovf=0.
REQ-031 Reset mid-group or in HOLD SHALL discard the partial or pending result without emitting it.
REQ-032 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-033 A shared package mac_pkg SHALL hold the state enum (ACC, HOLD) and the product width constant PROD_W=8.
REQ-034 The ACC_W-bit add with carry-out SHALL be a single sub-module named acc_adder, a parallel-prefix adder in the codebase's GREY/BLACK style.
REQ-035 The FSM, counter and registers SHALL stay in prod_accumulator.

Verification
REQ-036 Assert rst for 2 cycles, then release -> in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
REQ-037 Feed 15, 225, 1 (in_last on the 3rd), out_ready=1 -> one cycle later out_valid=1, out_sum=241, out_count=3, out_ovf=0; in_ready=1 again after the handshake.
REQ-038 Hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, no beats accepted, result fields unchanged; out_ready=1 -> exactly one transfer.
REQ-039 With ACC_W=10, feed 225 five times, last on the 5th -> out_sum=101, out_count=5, out_ovf=1.
REQ-040 With MAX_LEN=4, feed 1 six times with in_last=0 -> first result out_sum=4, out_count=4; the remaining 2 beats start the next group.
REQ-041 Feed 2 beats, then assert rst -> no out_valid; after release, beats 7 and 8 (last) -> out_sum=15, out_count=2.
